// File: rtl/alu_rx_tx_interface.sv
// Sequencer between the UART receiver/transmitter and a combinational ALU.
// Optional inter-byte timeout is enabled with `define ALU_IF_TIMEOUT_EN.
module alu_rx_tx_interface #(
  parameter int NB_DATA        = 8,
  parameter int NB_OPCODE      = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NB_DATA-1:0]   i_rx_data,
  input  logic                 i_rx_done,
  input  logic [NB_DATA-1:0]   i_alu_result,
  input  logic                 i_tx_done,
  output logic [NB_DATA-1:0]   o_first_operator,
  output logic [NB_DATA-1:0]   o_second_operator,
  output logic [NB_OPCODE-1:0] o_opcode,
  output logic [NB_DATA-1:0]   o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy,
  output logic                 o_timeout
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [NB_DATA-1:0]   a_q, a_d;
  logic [NB_DATA-1:0]   b_q, b_d;
  logic [NB_OPCODE-1:0] op_q, op_d;
  logic [NB_DATA-1:0]   tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 tmo_hit;

`ifdef ALU_IF_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q;
  logic          in_gap;

  // Only the gaps inside a partially received transaction are timed.
  assign in_gap  = (state_q == WAIT_B) || (state_q == WAIT_OP);
  assign tmo_hit = in_gap && !i_rx_done && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!in_gap || i_rx_done || tmo_hit) cnt_d = '0;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= tmo_hit;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign tmo_hit   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    case (state_q)
      WAIT_A: begin
        if (i_rx_done) begin
          a_d     = i_rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          b_d     = i_rx_data;
          state_d = WAIT_OP;
        end else if (tmo_hit) begin
          state_d = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          op_d    = i_rx_data[NB_OPCODE-1:0];
          busy_d  = 1'b1;
          state_d = SEND;
        end else if (tmo_hit) begin
          state_d = WAIT_A;
        end
      end
      SEND: begin
        // ALU inputs settled during this cycle; capture its result.
        tx_d    = i_alu_result;
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          busy_d  = 1'b0;
          state_d = WAIT_A;
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tx_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign o_first_operator  = a_q;
  assign o_second_operator = b_q;
  assign o_opcode          = op_q;
  assign o_tx_data         = tx_q;
  assign o_tx_start        = (state_q == SEND);
  assign o_busy            = busy_q;

endmodule

// File: tb/tb_alu_rx_tx_interface.sv
// Directed bench for alu_rx_tx_interface with a small behavioural ALU attached.
`timescale 1ns/1ps
module tb_alu_rx_tx_interface;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] alu_res;
  logic       tx_done;
  logic [7:0] a_o, b_o, tx_data;
  logic [5:0] op_o;
  logic       tx_start, busy, tmo;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_tmo    = 0;

  always #5 clk = ~clk;

  alu_rx_tx_interface #(.NB_DATA(8), .NB_OPCODE(6), .TIMEOUT_CYCLES(16)) dut (
    .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_alu_result(alu_res), .i_tx_done(tx_done),
    .o_first_operator(a_o), .o_second_operator(b_o), .o_opcode(op_o),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy), .o_timeout(tmo)
  );

  // Environment ALU: returns 0 for unknown opcodes.
  always_comb begin
    case (op_o)
      6'h20:   alu_res = a_o + b_o;
      6'h22:   alu_res = a_o - b_o;
      6'h24:   alu_res = a_o & b_o;
      6'h25:   alu_res = a_o | b_o;
      6'h26:   alu_res = a_o ^ b_o;
      6'h27:   alu_res = ~(a_o | b_o);
      6'h03:   alu_res = $unsigned($signed(a_o) >>> b_o);
      6'h02:   alu_res = a_o >> b_o;
      default: alu_res = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (tx_start) n_start++;
    if (tmo)      n_tmo++;
  end

  typedef struct {
    logic [7:0] a, b, op;
    logic [5:0] exp_op;
    logic [7:0] exp_tx;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  // Runs one transaction up to WAIT_TX; tx_done is left to the caller.
  task automatic run_txn(input vec_t v, input string tag);
    int s0;
    s0 = n_start;
    send_byte(v.a);
    send_byte(v.b);
    rx_data = v.op;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    chk({tag, " start_n+1"}, tx_start, 1'b1);
    chk({tag, " opcode"}, op_o, v.exp_op);
    chk({tag, " busy"}, busy, 1'b1);
    chk({tag, " opA"}, a_o, v.a);
    chk({tag, " opB"}, b_o, v.b);
    @(negedge clk);
    chk({tag, " start_once"}, tx_start, 1'b0);
    chk({tag, " tx_data"}, tx_data, v.exp_tx);
    idle(2);
    chk({tag, " tx_data_hold"}, tx_data, v.exp_tx);
    chk({tag, " n_start"}, n_start - s0, 1);
  endtask

  task automatic finish_txn(input string tag);
    pulse_tx_done();
    chk({tag, " busy_clr"}, busy, 1'b0);
  endtask

  initial begin
    int s0;
    vecs[0] = '{a:8'h05, b:8'h03, op:8'h20, exp_op:6'h20, exp_tx:8'h08};
    vecs[1] = '{a:8'h03, b:8'h05, op:8'h22, exp_op:6'h22, exp_tx:8'hFE};
    vecs[2] = '{a:8'h80, b:8'h02, op:8'h03, exp_op:6'h03, exp_tx:8'hE0};
    vecs[3] = '{a:8'h0F, b:8'hF0, op:8'h25, exp_op:6'h25, exp_tx:8'hFF};
    vecs[4] = '{a:8'h0F, b:8'hF0, op:8'hFF, exp_op:6'h3F, exp_tx:8'h00};
    vecs[5] = '{a:8'h01, b:8'h01, op:8'h20, exp_op:6'h20, exp_tx:8'h02};
    vecs[6] = '{a:8'h04, b:8'h04, op:8'h24, exp_op:6'h24, exp_tx:8'h04};

    rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
    idle(3);
    chk("rst opA", a_o, 8'h00);
    chk("rst opB", b_o, 8'h00);
    chk("rst opcode", op_o, 6'h00);
    chk("rst tx_data", tx_data, 8'h00);
    chk("rst outputs", {tx_start, busy, tmo}, 3'b000);
    rst = 1'b0;
    idle(2);

    // ADD, then SUB and SRA back to back
    s0 = n_start;
    for (int i = 0; i < 3; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
      finish_txn($sformatf("vec%0d", i));
    end
    chk("b2b pulses", n_start - s0, 3);

    // tx_done outside WAIT_TX is ignored
    pulse_tx_done();
    chk("stray tx_done busy", busy, 1'b0);

    // Bytes in WAIT_TX are dropped
    run_txn(vecs[3], "or");
    s0 = n_start;
    send_byte(8'hAA);
    send_byte(8'h55);
    chk("drop opA", a_o, 8'h0F);
    chk("drop opB", b_o, 8'hF0);
    chk("drop busy", busy, 1'b1);
    finish_txn("or");
    chk("drop no start", n_start - s0, 0);

    // Unknown opcode, upper bits masked
    run_txn(vecs[4], "inv");
    finish_txn("inv");

    // Asynchronous reset after operand A
    send_byte(8'h12);
    chk("pre-rst opA", a_o, 8'h12);
    s0 = n_start;
    #2 rst = 1'b1;
    #1;
    chk("async rst opA", a_o, 8'h00);
    chk("async rst outs", {b_o, op_o, tx_data, tx_start, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    chk("rst no start", n_start - s0, 0);
    run_txn(vecs[5], "post_rst");
    finish_txn("post_rst");

    // Inter-byte idle gap
    s0 = n_start;
    send_byte(8'h07);
    idle(20);
`ifdef ALU_IF_TIMEOUT_EN
    chk("timeout pulses", n_tmo, 1);
    chk("timeout no start", n_start - s0, 0);
    chk("timeout keeps opA", a_o, 8'h07);
    run_txn(vecs[6], "post_tmo");
    finish_txn("post_tmo");
`else
    chk("no timeout", n_tmo, 0);
    send_byte(8'h04);
    send_byte(8'h24);
    chk("gap start", tx_start, 1'b1);
    chk("gap opA", a_o, 8'h07);
    @(negedge clk);
    chk("gap tx_data", tx_data, 8'h04);
    finish_txn("gap");
`endif

    // Simultaneous tx_done and rx_done in WAIT_TX
    run_txn(vecs[0], "sim");
    @(negedge clk);
    rx_data = 8'h09; rx_done = 1'b1; tx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; tx_done = 1'b0;
    chk("sim busy", busy, 1'b0);
    chk("sim opA kept", a_o, 8'h05);
    idle(2);
    send_byte(8'h33);
    chk("sim back in WAIT_A", a_o, 8'h33);
    chk("sim opB kept", b_o, 8'h03);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1);
  end

endmodule

// File: doc/alu_rx_tx_interface.md
Name: alu_rx_tx_interface

Overview:
Sequencer between the UART byte receiver/transmitter and the combinational ALU.
- Collects three received bytes in order: first operand, second operand, opcode.
- Drives them into the ALU and captures the ALU result.
- Hands the result to the UART transmitter with a start/done handshake, then rearms for the next transaction.

Parameters:
- NB_DATA, 8, width of operands, result and UART data bytes
- NB_OPCODE, 6, width of the ALU opcode (taken from LSBs of the opcode byte)
- TIMEOUT_CYCLES, 1000000, idle cycles tolerated between bytes of one transaction (used only with the optional feature)

Ports:
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_rx_data  in  NB_DATA  byte from UART receiver
- i_rx_done  in  1  one-cycle strobe: i_rx_data valid
- i_alu_result  in  NB_DATA  result from ALU (combinational from o_first_operator/o_second_operator/o_opcode)
- i_tx_done  in  1  one-cycle strobe: transmitter finished current byte
- o_first_operator  out  NB_DATA  operand A to ALU, registered
- o_second_operator  out  NB_DATA  operand B to ALU, registered
- o_opcode  out  NB_OPCODE  opcode to ALU, registered
- o_tx_data  out  NB_DATA  byte to UART transmitter, registered
- o_tx_start  out  1  one-cycle strobe: start transmission of o_tx_data
- o_busy  out  1  high from opcode capture until i_tx_done accepted
- o_timeout  out  1  one-cycle strobe: partial transaction abandoned (0 without optional feature)

Behaviour:
- Clocking and reset: single clock domain, asynchronous active-high reset.
- Reset values: all outputs 0; state WAIT_A; timeout counter 0.
- Reset asserted mid-transaction discards all captured bytes; no o_tx_start is emitted for the aborted transaction.
- States:
  - WAIT_A: on i_rx_done, o_first_operator <= i_rx_data; go to WAIT_B.
  - WAIT_B: on i_rx_done, o_second_operator <= i_rx_data; go to WAIT_OP.
  - WAIT_OP: on i_rx_done, o_opcode <= i_rx_data[NB_OPCODE-1:0] (upper bits discarded); o_busy <= 1; go to SEND.
  - SEND: exactly one cycle. ALU inputs have been stable for one full cycle. o_tx_data <= i_alu_result; o_tx_start = 1 for this single cycle; go to WAIT_TX.
  - WAIT_TX: hold o_tx_data. On i_tx_done: o_busy <= 0; go to WAIT_A.
- Operand/opcode registers keep their values until overwritten by the next transaction.
- Latency: last opcode byte strobe (cycle N) -> o_tx_start high in cycle N+1, counted from the state register's update edge. Requirement: o_tx_start is asserted during the cycle immediately after the i_rx_done of the opcode byte is sampled.
- Bytes strobed in SEND or WAIT_TX are dropped silently; no queuing.
- i_tx_done outside WAIT_TX is ignored.
- i_rx_done and i_tx_done both high in WAIT_TX: tx_done is honoured, the rx byte is dropped, next state is WAIT_A.
- Invalid opcodes are not filtered. The ALU returns 0 for them, and 0x00 is transmitted.
- No arithmetic in this block; values pass through unmodified.

Optional Feature:
Macro: ALU_IF_TIMEOUT_EN
- Defined:
  - Counter of width clog2(TIMEOUT_CYCLES) runs only in WAIT_B and WAIT_OP.
  - Counter clears on every accepted byte and on entry to WAIT_A.
  - When the counter reaches TIMEOUT_CYCLES-1 with no i_rx_done in that cycle: state returns to WAIT_A, o_timeout pulses for one cycle, counter clears. Captured operand registers are not cleared.
  - i_rx_done in the same cycle as the terminal count wins: the byte is accepted, no timeout.
- Not defined: no counter exists; the block waits indefinitely; o_timeout tied to 0.

Test Plan:
1. ADD: rx bytes 0x05, 0x03, 0x20 -> o_opcode=0x20, single o_tx_start one cycle after third strobe, o_tx_data=0x08; after i_tx_done, o_busy=0 and state WAIT_A.
2. SUB and SRA back-to-back:
   - 0x03, 0x05, 0x22 -> 0xFE.
   - Then 0x80, 0x02, 0x03 -> 0xE0.
   - Exactly two o_tx_start pulses.
3. Dropped bytes and invalid opcode:
   - rx strobes 0xAA and 0x55 while in WAIT_TX -> ignored; next transaction 0x0F, 0xF0, 0x25 (OR) -> 0xFF.
   - Opcode byte 0xFF (masked to 0x3F) -> 0x00 transmitted.
4. Reset mid-operation: assert i_reset after operand A 0x12 received -> all outputs 0 immediately (asynchronous). Then 0x01, 0x01, 0x20 -> 0x02.
5. Timeout, with ALU_IF_TIMEOUT_EN and TIMEOUT_CYCLES=16: byte 0x07, then 16 idle cycles -> o_timeout pulses once, no o_tx_start. Then 0x04, 0x04, 0x24 -> 0x04.
6. Simultaneous i_tx_done and i_rx_done (byte 0x09) in WAIT_TX -> returns to WAIT_A; o_first_operator unchanged (0x09 not captured).
